// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one UART transmitter between two byte-stream requesters.
// Requester 0 is the trace-buffer dump path. Requester 1 is the
// configuration ack/status path. Bytes of two packets are never
// interleaved, and ties between the requesters are broken round-robin.
// After each packet's last byte, the arbiter holds the UART for
// IDLE_GAP idle cycles before it arbitrates again.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   req_valid    [1:0] per-requester byte available
//   req_data0    [7:0] byte from requester 0
//   req_data1    [7:0] byte from requester 1
//   req_last     [1:0] per-requester last-byte-of-packet marker
//   req_ready    [1:0] combinational accept pulse (LOAD state only)
//   tx_data      [7:0] byte presented to the UART, held from LOAD to LOAD
//   new_tx_data  one-cycle registered start pulse to the UART
//   tx_busy      UART busy flag
//   grant        [1:0] one-hot UART owner, 00 when unowned
//   busy         high whenever the FSM is not IDLE
//   pkt_count    [CNT_WIDTH-1:0] completed packets, wraps
module uart_tx_arbiter #(
    parameter int IDLE_GAP  = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic [7:0]           req_data0,
    input  logic [7:0]           req_data1,
    input  logic [1:0]           req_last,
    output logic [1:0]           req_ready,
    output logic [7:0]           tx_data,
    output logic                 new_tx_data,
    input  logic                 tx_busy,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_count
);

    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             last_grant_q;   // index of the requester granted most recently
    logic             last_byte_q;    // byte in flight closes its packet
    logic [GAP_W-1:0] gap_cnt_q;

    logic             grant_take;
    logic             grant_idx;
    logic             load_byte;
    logic             pkt_done;
    logic             g;              // index of the current owner

    // grant is one-hot, so bit 1 is the owner's index
    assign g    = grant[1];
    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        req_ready  = 2'b00;
        grant_take = 1'b0;
        grant_idx  = 1'b0;
        load_byte  = 1'b0;
        pkt_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid != 2'b00) begin
                    grant_take = 1'b1;
                    // On a tie the requester not served last wins.
                    grant_idx  = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                // Wait indefinitely for the owner. Ownership is kept so
                // packets are never interleaved.
                if (req_valid[g]) begin
                    req_ready[g] = 1'b1;
                    load_byte    = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!tx_busy) begin
                    if (last_byte_q) begin
                        pkt_done = 1'b1;
                        state_d  = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_GAP: begin
                // The counter holds the cycles left including this one.
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tx_data      <= 8'h00;
            new_tx_data  <= 1'b0;
            grant        <= 2'b00;
            pkt_count    <= '0;
            last_byte_q  <= 1'b0;
            last_grant_q <= 1'b1;   // requester 0 wins the first tie
            gap_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            new_tx_data <= (state_d == S_START);
            if (grant_take) begin
                grant        <= grant_idx ? 2'b10 : 2'b01;
                last_grant_q <= grant_idx;
            end
            if (load_byte) begin
                tx_data     <= g ? req_data1 : req_data0;
                last_byte_q <= req_last[g];
            end
            if (pkt_done) begin
                pkt_count <= pkt_count + CNT_WIDTH'(1);
                grant     <= 2'b00;
                gap_cnt_q <= GAP_W'(IDLE_GAP);
            end else if (state_q == S_GAP) begin
                gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;           // 0: dut (IDLE_GAP=2), 1: dut_g0 (IDLE_GAP=0)
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_last = 2'b00;
    logic [7:0]  req_data0 = 8'h00;
    logic [7:0]  req_data1 = 8'h00;
    logic        tx_busy;

    logic [1:0]  req_ready, rdy_a, rdy_b;
    logic [7:0]  tx_data, txd_a, txd_b;
    logic        new_tx_data, ntx_a, ntx_b;
    logic [1:0]  grant, gnt_a, gnt_b;
    logic        busy, busy_a, busy_b;
    logic [15:0] pkt_count, pc_a;
    logic [3:0]  pc_b;
    logic        rst_a, rst_b;

    assign rst_a       = reset | sel;
    assign rst_b       = reset | ~sel;
    assign req_ready   = sel ? rdy_b : rdy_a;
    assign tx_data     = sel ? txd_b : txd_a;
    assign new_tx_data = sel ? ntx_b : ntx_a;
    assign grant       = sel ? gnt_b : gnt_a;
    assign busy        = sel ? busy_b : busy_a;
    assign pkt_count   = sel ? {12'h000, pc_b} : pc_a;

    uart_tx_arbiter #(.IDLE_GAP(2), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(rst_a), .req_valid(req_valid), .req_data0(req_data0),
        .req_data1(req_data1), .req_last(req_last), .req_ready(rdy_a), .tx_data(txd_a),
        .new_tx_data(ntx_a), .tx_busy(tx_busy), .grant(gnt_a), .busy(busy_a), .pkt_count(pc_a)
    );

    uart_tx_arbiter #(.IDLE_GAP(0), .CNT_WIDTH(4)) dut_g0 (
        .clk(clk), .reset(rst_b), .req_valid(req_valid), .req_data0(req_data0),
        .req_data1(req_data1), .req_last(req_last), .req_ready(rdy_b), .tx_data(txd_b),
        .new_tx_data(ntx_b), .tx_busy(tx_busy), .grant(gnt_b), .busy(busy_b), .pkt_count(pc_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int cyc = 0;
    int busy_len = 10;
    int busy_cnt = 0;
    logic en0 = 1'b1;
    logic en1 = 1'b1;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int n = 0;
        while (pulse_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (pulse_cnt < target) chk("timeout_pulses", pulse_cnt, target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || busy) begin
            checks++;
            failures++;
            $display("FAIL timeout_idle actual=pending:%0d busy:%0b expected=pending:0 busy:0",
                     exp_q.size(), busy);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy for busy_len cycles after each start pulse
    always @(posedge clk) begin
        if (new_tx_data) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Requester models: present the queue front, pop on accept
    always @(posedge clk) begin
        if (req_valid[0] && req_ready[0] && q0.size() != 0) void'(q0.pop_front());
        if (req_valid[1] && req_ready[1] && q1.size() != 0) void'(q1.pop_front());
        req_valid[0] <= en0 && (q0.size() != 0);
        req_valid[1] <= en1 && (q1.size() != 0);
        if (q0.size() != 0) begin
            req_data0   <= q0[0][7:0];
            req_last[0] <= q0[0][8];
        end
        if (q1.size() != 0) begin
            req_data1   <= q1[0][7:0];
            req_last[1] <= q1[0][8];
        end
    end

    // Scoreboard monitor: every start pulse must match the next expected {grant, byte}
    always @(negedge clk) begin
        if (new_tx_data) begin
            pulse_cnt <= pulse_cnt + 1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=%0h_%0h expected=none", grant, tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("tx_byte", {22'h0, grant, tx_data}, {22'h0, mon_e});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, pk, n, c_pkt, c_rdy, prev;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_new_tx", new_tx_data, 0);
        chk("rst_ready", req_ready, 0);
        reset = 1'b0;

        // Round-robin: two 2-byte packets on each requester, order 0,1,0,1
        q0.push_back({1'b0, 8'h10}); q0.push_back({1'b1, 8'h11});
        q0.push_back({1'b0, 8'h12}); q0.push_back({1'b1, 8'h13});
        q1.push_back({1'b0, 8'h20}); q1.push_back({1'b1, 8'h21});
        q1.push_back({1'b0, 8'h22}); q1.push_back({1'b1, 8'h23});
        exp_q.push_back({2'b01, 8'h10}); exp_q.push_back({2'b01, 8'h11});
        exp_q.push_back({2'b10, 8'h20}); exp_q.push_back({2'b10, 8'h21});
        exp_q.push_back({2'b01, 8'h12}); exp_q.push_back({2'b01, 8'h13});
        exp_q.push_back({2'b10, 8'h22}); exp_q.push_back({2'b10, 8'h23});
        wait_idle(1000);
        chk("rr_pkt_count", pkt_count, 4);

        // Single packet A1 A2 A3, then gap timing
        base = pulse_cnt;
        q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
        exp_q.push_back({2'b01, 8'hA1}); exp_q.push_back({2'b01, 8'hA2});
        exp_q.push_back({2'b01, 8'hA3});
        wait_pulses(base + 3, 500);
        tick();
        n = 0;
        while (tx_busy && n < 100) begin tick(); n++; end
        chk("single_busy_wait_exit", busy, 1);
        tick(); tick();
        chk("single_busy_in_gap", busy, 1);
        tick();
        chk("single_busy_idle", busy, 0);
        chk("single_pkt_count", pkt_count, 5);
        chk("single_grant_clear", grant, 0);

        // No pre-emption: requester 1 arrives during byte 2 of a 4-byte packet
        base = pulse_cnt;
        pk = int'(pkt_count);
        q0.push_back({1'b0, 8'h31}); q0.push_back({1'b0, 8'h32});
        q0.push_back({1'b0, 8'h33}); q0.push_back({1'b1, 8'h34});
        exp_q.push_back({2'b01, 8'h31}); exp_q.push_back({2'b01, 8'h32});
        exp_q.push_back({2'b01, 8'h33}); exp_q.push_back({2'b01, 8'h34});
        wait_pulses(base + 2, 500);
        q1.push_back({1'b0, 8'h81}); q1.push_back({1'b1, 8'h82});
        exp_q.push_back({2'b10, 8'h81}); exp_q.push_back({2'b10, 8'h82});
        c_pkt = -1000;
        c_rdy = -1;
        n = 0;
        while (c_rdy < 0 && n < 500) begin
            tick();
            n++;
            if (c_pkt < 0 && int'(pkt_count) != pk) c_pkt = cyc;
            if (req_ready[1]) c_rdy = cyc;
        end
        // pkt_count is seen in the first GAP cycle; ready comes 2 GAP + 1 IDLE cycles on
        chk("nopreempt_ready_delay", c_rdy - c_pkt, 3);
        wait_idle(1000);
        chk("nopreempt_pkt_count", pkt_count, 7);

        // Stalled requester: valid drops while owning the UART
        base = pulse_cnt;
        q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42}); q0.push_back({1'b1, 8'h43});
        exp_q.push_back({2'b01, 8'h41}); exp_q.push_back({2'b01, 8'h42});
        exp_q.push_back({2'b01, 8'h43});
        wait_pulses(base + 1, 500);
        en0 = 1'b0;
        tick();
        n = 0;
        while (tx_busy && n < 100) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_no_pulse", new_tx_data, 0);
            chk("stall_grant", grant, 2'b01);
            chk("stall_ready", req_ready, 0);
        end
        en0 = 1'b1;
        wait_idle(1000);
        chk("stall_pkt_count", pkt_count, 8);

        // Reset while in WAIT with the UART busy
        base = pulse_cnt;
        q0.push_back({1'b0, 8'h51}); q0.push_back({1'b0, 8'h52}); q0.push_back({1'b1, 8'h53});
        exp_q.push_back({2'b01, 8'h51});
        wait_pulses(base + 1, 500);
        tick();
        reset = 1'b1;
        q0.delete();
        tick();
        chk("wrst_tx_data", tx_data, 0);
        chk("wrst_new_tx", new_tx_data, 0);
        chk("wrst_grant", grant, 0);
        chk("wrst_ready", req_ready, 0);
        chk("wrst_busy", busy, 0);
        chk("wrst_pkt", pkt_count, 0);
        reset = 1'b0;
        repeat (20) tick();
        chk("wrst_no_more_pulses", pulse_cnt, base + 1);
        q0.push_back({1'b1, 8'h61});
        q1.push_back({1'b1, 8'h71});
        exp_q.push_back({2'b01, 8'h61});
        exp_q.push_back({2'b10, 8'h71});
        wait_idle(1000);
        chk("wrst_tie_pkt_count", pkt_count, 2);

        // IDLE_GAP = 0, 4-bit counter: 17 back-to-back 1-byte packets wrap 15 -> 0 -> 1
        sel = 1'b1;
        busy_len = 2;
        tick(); tick();
        chk("g0_rst_pkt", pkt_count, 0);
        for (int k = 1; k <= 17; k++) begin
            q1.push_back({1'b1, 8'(k)});
            exp_q.push_back({2'b10, 8'(k)});
        end
        prev = 0;
        for (int k = 1; k <= 17; k++) begin
            n = 0;
            while (int'(pkt_count) == prev && n < 200) begin tick(); n++; end
            chk("g0_pkt_count", pkt_count, k % 16);
            chk("g0_idle_grant", grant, 0);
            chk("g0_idle_busy", busy, 0);
            prev = int'(pkt_count);
            if (k < 17) begin
                tick();
                chk("g0_regrant", grant, 2'b10);
            end
        end
        wait_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
